// File: rtl/sfp_stream_link.sv
// Transport stage below the SFP data handler: splits a handler word into AXI4-Stream beats
// on TX and rebuilds beats into a handler word on RX, with length checking and debug state.
module sfp_stream_link #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_DATA_BIT         = 64,
  parameter int C_BEAT_NUM         = C_DATA_BIT / C_AXIS_TDATA_WIDTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  // handler TX side
  input  logic [C_DATA_BIT-1:0]         i_tx_stream_data,
  input  logic                          i_sfp_start_flag,
  output logic                          o_tx_busy,
  output logic                          o_tx_done,
  // stream TX side
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  // stream RX side
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  // handler RX side
  output logic [C_DATA_BIT-1:0]         o_rx_stream_data,
  output logic                          o_sfp_end_flag,
  // status
  output logic                          o_rx_len_err,
  output logic                          o_tx_start_drop,
  output logic [3:0]                    o_link_state
);

  localparam int W     = C_AXIS_TDATA_WIDTH;
  localparam int D     = C_DATA_BIT;
  localparam int CNT_W = $clog2(C_BEAT_NUM + 1);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(C_BEAT_NUM - 1);
  localparam logic [CNT_W-1:0] BEAT_NUM = CNT_W'(C_BEAT_NUM);

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_SEND = 2'd1;

  localparam logic [1:0] RX_IDLE    = 2'd0;
  localparam logic [1:0] RX_COLLECT = 2'd1;
  localparam logic [1:0] RX_DISCARD = 2'd2;

  // ---------------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------------
  logic [1:0]       tx_state, tx_state_next;
  logic [D-1:0]     tx_shift, tx_shift_next;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_next;
  logic             tx_done_next;
  logic             tx_drop_next;
  logic             tx_hs;

  assign m_axis_tvalid = (tx_state == TX_SEND);
  assign m_axis_tdata  = tx_shift[D-1 -: W];
  assign m_axis_tlast  = m_axis_tvalid && (tx_cnt == LAST_IDX);
  assign o_tx_busy     = m_axis_tvalid;
  assign tx_hs         = m_axis_tvalid && m_axis_tready;

  always_comb begin
    tx_state_next = tx_state;
    tx_shift_next = tx_shift;
    tx_cnt_next   = tx_cnt;
    tx_done_next  = 1'b0;
    tx_drop_next  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (i_sfp_start_flag) begin
          tx_shift_next = i_tx_stream_data;
          tx_cnt_next   = '0;
          tx_state_next = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_drop_next = i_sfp_start_flag;
        if (tx_hs) begin
          // MSB beat goes first, so the next beat slides into the top W bits
          tx_shift_next = {tx_shift[D-W-1:0], {W{1'b0}}};
          if (m_axis_tlast) begin
            tx_cnt_next   = '0;
            tx_state_next = TX_IDLE;
            tx_done_next  = 1'b1;
          end else begin
            tx_cnt_next = tx_cnt + 1'b1;
          end
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state        <= TX_IDLE;
      tx_shift        <= '0;
      tx_cnt          <= '0;
      o_tx_done       <= 1'b0;
      o_tx_start_drop <= 1'b0;
    end else begin
      tx_state        <= tx_state_next;
      tx_shift        <= tx_shift_next;
      tx_cnt          <= tx_cnt_next;
      o_tx_done       <= tx_done_next;
      o_tx_start_drop <= tx_drop_next;
    end
  end

  // ---------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------
  logic [1:0]       rx_state, rx_state_next;
  logic [D-W-1:0]   rx_hist, rx_hist_next;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_next;
  logic [CNT_W-1:0] rx_cnt_inc;
  logic [D-1:0]     rx_word;
  logic             rx_end_next;
  logic             rx_err_next;
  logic             rx_hs;

  // rx_hist keeps only the previous N-1 beats; the current beat completes the word
  assign rx_word    = {rx_hist, s_axis_tdata};
  assign rx_cnt_inc = rx_cnt + 1'b1;
  assign rx_hs      = s_axis_tvalid && s_axis_tready;

  always_comb begin
    rx_state_next = rx_state;
    rx_hist_next  = rx_hist;
    rx_cnt_next   = rx_cnt;
    rx_end_next   = 1'b0;
    rx_err_next   = 1'b0;
    if (rx_hs) begin
      rx_hist_next = rx_word[D-W-1:0];
      if (s_axis_tlast) begin
        rx_state_next = RX_IDLE;
        rx_cnt_next   = '0;
        if ((rx_state != RX_DISCARD) && (rx_cnt_inc == BEAT_NUM)) begin
          rx_end_next = 1'b1;
        end else begin
          rx_err_next = 1'b1;
        end
      end else if ((rx_state == RX_DISCARD) || (rx_cnt_inc == BEAT_NUM)) begin
        rx_state_next = RX_DISCARD;
        rx_cnt_next   = '0;
      end else begin
        rx_state_next = RX_COLLECT;
        rx_cnt_next   = rx_cnt_inc;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state         <= RX_IDLE;
      rx_hist          <= '0;
      rx_cnt           <= '0;
      o_rx_stream_data <= '0;
      o_sfp_end_flag   <= 1'b0;
      o_rx_len_err     <= 1'b0;
      s_axis_tready    <= 1'b0;
    end else begin
      rx_state         <= rx_state_next;
      rx_hist          <= rx_hist_next;
      rx_cnt           <= rx_cnt_next;
      o_sfp_end_flag   <= rx_end_next;
      o_rx_len_err     <= rx_err_next;
      s_axis_tready    <= 1'b1;
      if (rx_end_next) begin
        o_rx_stream_data <= rx_word;
      end
    end
  end

  assign o_link_state = {rx_state, tx_state};

endmodule

// File: tb/tb_sfp_stream_link.sv
// Scoreboard bench for sfp_stream_link with W=32, N=2: TX beats and RX word/length events
// are queued as stimulus is driven and popped when the DUT produces them.
module tb_sfp_stream_link;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [63:0] i_tx_stream_data;
  logic        i_sfp_start_flag;
  logic        o_tx_busy;
  logic        o_tx_done;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [63:0] o_rx_stream_data;
  logic        o_sfp_end_flag;
  logic        o_rx_len_err;
  logic        o_tx_start_drop;
  logic [3:0]  o_link_state;

  sfp_stream_link #(
    .C_AXIS_TDATA_WIDTH(32),
    .C_DATA_BIT        (64)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_tx_stream_data(i_tx_stream_data),
    .i_sfp_start_flag(i_sfp_start_flag),
    .o_tx_busy       (o_tx_busy),
    .o_tx_done       (o_tx_done),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .o_rx_stream_data(o_rx_stream_data),
    .o_sfp_end_flag  (o_sfp_end_flag),
    .o_rx_len_err    (o_rx_len_err),
    .o_tx_start_drop (o_tx_start_drop),
    .o_link_state    (o_link_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          err;
    logic [63:0] word;
    int          at;
  } rx_exp_t;

  int          checks   = 0;
  int          failures = 0;
  rx_exp_t     rx_q[$];
  logic [32:0] rx_beats[$];
  logic [32:0] tx_q[$];
  logic [63:0] last_good = 64'h0;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_tx_stream_data = '0; i_sfp_start_flag = 1'b0; m_axis_tready = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    #12;
    checks++;
    if ({o_tx_busy, o_tx_done, m_axis_tvalid, m_axis_tlast, m_axis_tdata, o_rx_stream_data,
         o_sfp_end_flag, o_rx_len_err, o_tx_start_drop, o_link_state} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b valid=%b tdata=%h rx=%h state=%h, want all 0",
               o_tx_busy, m_axis_tvalid, m_axis_tdata, o_rx_stream_data, o_link_state);
    end
    checks++;
    if (s_axis_tready !== 1'b0) begin
      failures++; $display("FAIL reset_tready: got %b want 0", s_axis_tready);
    end
    tick(); tick();
    i_rst = 1'b0;
    #2;
    checks++;
    if (s_axis_tready !== 1'b0) begin
      failures++; $display("FAIL tready_before_clock: got %b want 0", s_axis_tready);
    end
    tick();
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++; $display("FAIL tready_after_release: got %b want 1", s_axis_tready);
    end
  endtask

  task automatic test_tx_basic(input logic [63:0] d);
    int beats = 0, busy_cyc = 0, done_cnt = 0, done_cyc = -1, last_hs = -1;
    logic [32:0] e;
    tx_q.push_back({1'b0, d[63:32]});
    tx_q.push_back({1'b1, d[31:0]});
    m_axis_tready = 1'b1; i_tx_stream_data = d; i_sfp_start_flag = 1'b1;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      failures++; $display("FAIL tx_idle_valid: got %b want 0", m_axis_tvalid);
    end
    tick();
    i_sfp_start_flag = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      failures++; $display("FAIL tx_latency: tvalid got %b want 1", m_axis_tvalid);
    end
    checks++;
    if (o_link_state !== 4'b0001) begin
      failures++; $display("FAIL tx_link_state: got %b want 0001", o_link_state);
    end
    for (int c = 0; c < 8; c++) begin
      if (o_tx_busy) busy_cyc++;
      if (o_tx_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats++; last_hs = c;
        checks++;
        if (tx_q.size() == 0) begin
          failures++; $display("FAIL tx_extra_beat: got %h with nothing expected", m_axis_tdata);
        end else begin
          e = tx_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e) begin
            failures++;
            $display("FAIL tx_beat: got last=%b data=%h want last=%b data=%h",
                     m_axis_tlast, m_axis_tdata, e[32], e[31:0]);
          end
        end
      end
      tick();
    end
    checks++;
    if (beats != 2 || tx_q.size() != 0) begin
      failures++; $display("FAIL tx_beat_count: got %0d want 2", beats);
    end
    checks++;
    if (busy_cyc != 2) begin
      failures++; $display("FAIL tx_busy_cycles: got %0d want 2", busy_cyc);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_hs + 1) begin
      failures++;
      $display("FAIL tx_done: got %0d pulses at %0d want 1 at %0d", done_cnt, done_cyc,
               last_hs + 1);
    end
    tx_q.delete();
  endtask

  task automatic test_tx_backpressure();
    int beats = 0, drop_cnt = 0, drop_cyc = -1;
    logic [32:0] e;
    tx_q.push_back({1'b0, 32'h11223344});
    tx_q.push_back({1'b1, 32'h55667788});
    i_tx_stream_data = 64'h1122334455667788; i_sfp_start_flag = 1'b1; m_axis_tready = 1'b0;
    tick();
    for (int c = 0; c < 12; c++) begin
      m_axis_tready    = (c >= 3);
      i_sfp_start_flag = (c == 1);
      if (c < 3) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h11223344) begin
          failures++;
          $display("FAIL tx_hold: got valid=%b data=%h want 1/11223344", m_axis_tvalid,
                   m_axis_tdata);
        end
      end
      if (o_tx_start_drop) begin
        drop_cnt++; drop_cyc = c;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        checks++;
        if (tx_q.size() == 0) begin
          failures++; $display("FAIL tx_bp_extra_beat: got %h", m_axis_tdata);
        end else begin
          e = tx_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e) begin
            failures++;
            $display("FAIL tx_bp_beat: got last=%b data=%h want last=%b data=%h",
                     m_axis_tlast, m_axis_tdata, e[32], e[31:0]);
          end
        end
      end
      tick();
    end
    i_sfp_start_flag = 1'b0; m_axis_tready = 1'b1;
    checks++;
    if (beats != 2) begin
      failures++; $display("FAIL tx_bp_beat_count: got %0d want 2", beats);
    end
    checks++;
    if (drop_cnt != 1 || drop_cyc != 2) begin
      failures++;
      $display("FAIL tx_start_drop: got %0d pulses at %0d want 1 at 2", drop_cnt, drop_cyc);
    end
    tx_q.delete();
  endtask

  // Drives the queued RX beats back-to-back, then compares each end/len_err event it sees.
  task automatic rx_run(input string name);
    int n = rx_beats.size();
    rx_exp_t x;
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++; $display("FAIL %s_tready: got %b want 1", name, s_axis_tready);
    end
    for (int i = 0; i <= n + 1; i++) begin
      if (i < n) begin
        {s_axis_tlast, s_axis_tdata} = rx_beats[i];
        s_axis_tvalid = 1'b1;
      end else begin
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
      end
      tick();
      if (o_sfp_end_flag || o_rx_len_err) begin
        checks++;
        if (rx_q.size() == 0) begin
          failures++;
          $display("FAIL %s_unexpected: got end=%b err=%b after beat %0d, none expected", name,
                   o_sfp_end_flag, o_rx_len_err, i);
        end else begin
          x = rx_q.pop_front();
          if (o_sfp_end_flag !== !x.err || o_rx_len_err !== x.err || x.at != i ||
              o_rx_stream_data !== x.word) begin
            failures++;
            $display("FAIL %s_event: got end=%b err=%b data=%h at %0d want err=%b data=%h at %0d",
                     name, o_sfp_end_flag, o_rx_len_err, o_rx_stream_data, i, x.err, x.word,
                     x.at);
          end
        end
      end
    end
    checks++;
    if (rx_q.size() != 0) begin
      failures++; $display("FAIL %s_missing: got %0d events left want 0", name, rx_q.size());
    end
    rx_q.delete();
    rx_beats.delete();
  endtask

  task automatic test_rx_good();
    rx_beats.push_back({1'b0, 32'hDEADBEEF});
    rx_beats.push_back({1'b1, 32'hCAFEF00D});
    last_good = 64'hDEADBEEFCAFEF00D;
    rx_q.push_back('{err: 1'b0, word: last_good, at: 1});
    rx_run("rx_good");
  endtask

  task automatic test_rx_length_errors();
    rx_beats.push_back({1'b1, 32'h12345678});
    rx_q.push_back('{err: 1'b1, word: last_good, at: 0});
    rx_run("rx_short");
    rx_beats.push_back({1'b0, 32'hA0A0A0A0});
    rx_beats.push_back({1'b0, 32'hB1B1B1B1});
    rx_beats.push_back({1'b1, 32'hC2C2C2C2});
    rx_q.push_back('{err: 1'b1, word: last_good, at: 2});
    rx_run("rx_long");
  endtask

  task automatic test_back_to_back();
    rx_beats.push_back({1'b0, 32'h01020304});
    rx_beats.push_back({1'b1, 32'h05060708});
    rx_beats.push_back({1'b0, 32'h90A0B0C0});
    rx_beats.push_back({1'b1, 32'hD0E0F000});
    rx_q.push_back('{err: 1'b0, word: 64'h0102030405060708, at: 1});
    rx_q.push_back('{err: 1'b0, word: 64'h90A0B0C0D0E0F000, at: 3});
    last_good = 64'h90A0B0C0D0E0F000;
    rx_run("rx_b2b");
  endtask

  task automatic test_reset_mid_frame();
    i_tx_stream_data = 64'hA5A5A5A55A5A5A5A; i_sfp_start_flag = 1'b1; m_axis_tready = 1'b0;
    s_axis_tdata = 32'h0BADF00D; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
    tick();
    i_sfp_start_flag = 1'b0; s_axis_tvalid = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1 || o_link_state !== 4'b0101) begin
      failures++;
      $display("FAIL mid_frame_state: got valid=%b state=%b want 1/0101", m_axis_tvalid,
               o_link_state);
    end
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || o_tx_busy !== 1'b0 || o_link_state !== 4'b0000 ||
        o_rx_stream_data !== 64'h0 || s_axis_tready !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got valid=%b busy=%b state=%b rx=%h ready=%b want all 0",
               m_axis_tvalid, o_tx_busy, o_link_state, o_rx_stream_data, s_axis_tready);
    end
    tick();
    i_rst = 1'b0;
    last_good = 64'h0;
    m_axis_tready = 1'b1;
    tick();
    rx_beats.push_back({1'b0, 32'h13572468});
    rx_beats.push_back({1'b1, 32'h9ACEBDF0});
    last_good = 64'h135724689ACEBDF0;
    rx_q.push_back('{err: 1'b0, word: last_good, at: 1});
    rx_run("rx_after_reset");
    test_tx_basic(64'hFEDCBA9876543210);
  endtask

  initial begin
    test_reset();
    test_tx_basic(64'h1122334455667788);
    test_tx_backpressure();
    test_rx_good();
    test_rx_length_errors();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfp_stream_link.md
Name: sfp_stream_link

Overview:
- Transport stage directly downstream of the SFP data handler.
- TX path: takes the handler's outgoing data word and start pulse, splits the word into AXI4-Stream beats, and sends them to the SFP/Aurora transmit interface.
- RX path: collects incoming AXI4-Stream beats back into one data word, presents it as the handler's receive word, and pulses the end flag.
- Also reports link errors and a debug state.

Parameters:
- C_AXIS_TDATA_WIDTH, 32, width of one stream beat (W).
- C_DATA_BIT, 64, width of one handler data word. Must be an integer multiple of W.
- C_BEAT_NUM, C_DATA_BIT/C_AXIS_TDATA_WIDTH, beats per word (N). N must be 2 or more.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_tx_stream_data  in  C_DATA_BIT  word to transmit
- i_sfp_start_flag  in  1  one-cycle pulse: send i_tx_stream_data
- o_tx_busy  out  1  high while a TX frame is in progress
- o_tx_done  out  1  one-cycle pulse after the last TX beat is accepted
- m_axis_tdata  out  W  TX beat data
- m_axis_tvalid  out  1  TX beat valid
- m_axis_tlast  out  1  marks the final beat of a frame
- m_axis_tready  in  1  TX sink ready
- s_axis_tdata  in  W  RX beat data
- s_axis_tvalid  in  1  RX beat valid
- s_axis_tlast  in  1  RX final beat
- s_axis_tready  out  1  RX ready
- o_rx_stream_data  out  C_DATA_BIT  last correctly received word
- o_sfp_end_flag  out  1  one-cycle pulse: new o_rx_stream_data available
- o_rx_len_err  out  1  one-cycle pulse: RX frame had the wrong beat count
- o_tx_start_drop  out  1  one-cycle pulse: start arrived while busy and was ignored
- o_link_state  out  4  {rx_state[1:0], tx_state[1:0]}, for debug

Behaviour:
- Reset (asynchronous, takes effect immediately): every output is 0 except s_axis_tready. s_axis_tready is 0 while i_rst is high and 1 from the first clock after i_rst is released. Both FSMs return to IDLE, all counters clear, o_rx_stream_data is 0. A partial frame cut by reset is discarded and is not resumed.
- TX FSM states: TX_IDLE=0, TX_SEND=1.
- TX_IDLE, i_sfp_start_flag=1 at a clock edge:
  - latch i_tx_stream_data into the TX shift register; beat counter = 0;
  - go to TX_SEND; m_axis_tvalid=1 from the next cycle.
  - Latency from start pulse to first tvalid: 1 cycle.
- TX_SEND:
  - m_axis_tdata = the upper W bits of the shift register (MSB beat first).
  - m_axis_tlast = 1 when the beat counter is N-1.
  - tdata, tvalid and tlast hold steady until tvalid&tready.
  - On each handshake: shift the register left by W and increment the counter.
  - On the handshake of the last beat: go to TX_IDLE; tvalid drops on the next cycle; o_tx_done pulses that same cycle.
- i_sfp_start_flag while in TX_SEND: ignored, o_tx_start_drop pulses next cycle, the current frame is unaffected. A start in the first TX_IDLE cycle after done is accepted normally.
- o_tx_busy = (tx_state == TX_SEND).
- RX FSM states: RX_IDLE=0, RX_COLLECT=1, RX_DISCARD=2.
- s_axis_tready is 1 in every RX state; the RX path never back-pressures.
- Any RX handshake: shift the register left by W and insert s_axis_tdata (MSB beat first); the beat counter increments.
- RX handshake in RX_IDLE with tlast=0: go to RX_COLLECT.
- RX handshake with tlast=1 and beat count (including this beat) == N:
  - next cycle: o_rx_stream_data = the assembled word, o_sfp_end_flag pulses for 1 cycle;
  - counter clears, return to RX_IDLE.
- RX handshake with tlast=1 and count < N (short frame):
  - o_rx_len_err pulses next cycle; o_rx_stream_data is unchanged; no end flag;
  - counter clears, return to RX_IDLE. This includes a single-beat frame seen in RX_IDLE.
- The N-th beat arriving with tlast=0 (long frame): go to RX_DISCARD; drop beats until the tlast handshake; then o_rx_len_err pulses, return to RX_IDLE, no end flag.
- TX and RX run fully independently; simultaneous TX and RX activity is legal.
- o_sfp_end_flag and o_rx_len_err are never both high.
- Consecutive frames back-to-back (tvalid continuously high) must produce one end flag per good frame, with no lost beats.

Test Plan:
- W=32, N=2. Start pulse with data 0x1122334455667788, tready=1 → tvalid from the next cycle; beat0 0x11223344 tlast=0; beat1 0x55667788 tlast=1; o_tx_done pulse; busy for exactly 2 cycles.
- Same start, tready held low for 3 cycles on beat0 → tdata stays 0x11223344 and tvalid stays 1 throughout. A second start pulse during the frame → o_tx_start_drop pulse; only 2 beats sent.
- RX beats 0xDEADBEEF, then 0xCAFEF00D with tlast → o_rx_stream_data = 0xDEADBEEFCAFEF00D; end flag for 1 cycle; len_err stays 0.
- RX single beat with tlast → len_err pulse; o_rx_stream_data keeps its previous value. RX 3-beat frame → len_err only after the 3rd beat; no end flag.
- Two good RX frames back-to-back with continuous tvalid → two end flags, two correct words.
- Assert i_rst in the middle of both a TX and an RX frame → tvalid drops immediately; after release a fresh RX frame is received correctly and a fresh start sends both beats.
